// File: rtl/router_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_pkg
//  Description : Shared types and constants for the router local-port
//                receiver: parser state encoding, statistics counter width
//                and the FIFO pointer-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_rx_pkg;

  // Packet parser states: header flit, size flit, payload flits
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_SIZE = 2'd1,
    S_PAY  = 2'd2
  } rx_state_t;

  localparam int RX_CNT_WIDTH = 32;

  // Pointer width for a power-of-two FIFO of the given depth
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_rx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_port_if
//  Description : Link-side flit handshake (rx/data/credit) and payload
//                output stream (valid/ready/data/sop/eop) of the receiver.
//                slave  = the receiver port itself
//                master = the environment (transmitter + downstream sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_rx_port_if #(
  parameter int FLIT_WIDTH = 16
);
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLIT_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;

  modport slave (
    input  rx, data_i, out_ready,
    output credit_o, out_valid, out_data, out_sop, out_eop
  );

  modport master (
    output rx, data_i, out_ready,
    input  credit_o, out_valid, out_data, out_sop, out_eop
  );
endinterface
`default_nettype wire

// File: rtl/router_rx_port_flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : flit_fifo
//  Description : First-word-fall-through flit buffer. dout always shows the
//                oldest entry; pop on empty and push on full are ignored.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo
  import router_rx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [WIDTH-1:0]                 din,
  output logic [WIDTH-1:0]                 dout,
  output logic [fifo_ptr_width(DEPTH):0]   count,
  output logic                             full,
  output logic                             empty
);

  localparam int PTR_W = fifo_ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/router_rx_port.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_port
//  Description : Router local-port receiver. Accepts flits under credit flow
//                control into a FWFT buffer, parses header / size / payload
//                and presents the payload as a valid/ready stream with
//                sop/eop delimiters.
//                Optional: ROUTER_RX_PORT_STATS_EN adds packet, flit and
//                stall counters (pkt_cnt_o, flit_cnt_o, stall_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module router_rx_port
  import router_rx_pkg::*;
#(
  parameter int FLIT_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  router_rx_port_if.slave         link,
  output logic [FLIT_WIDTH-1:0]   hdr_o,
  output logic [FLIT_WIDTH-1:0]   size_o,
  output logic                    pkt_done_o,
  output logic                    ovf_o
`ifdef ROUTER_RX_PORT_STATS_EN
  ,
  output logic [RX_CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [RX_CNT_WIDTH-1:0] flit_cnt_o,
  output logic [RX_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  localparam int PTR_W = fifo_ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [FLIT_WIDTH-1:0] fifo_head;
  logic [PTR_W:0]        fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  credit;

  rx_state_t             state_q, state_d;
  logic [FLIT_WIDTH-1:0] hdr_q, hdr_d;
  logic [FLIT_WIDTH-1:0] size_q, size_d;
  logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
  logic                  first_q, first_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;

  // Credit comes straight from the registered occupancy, so it is glitch-free
  assign credit    = (fifo_count != DEPTH_CNT);
  assign fifo_push = link.rx && credit;

  flit_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (link.data_i),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Parser next-state, head pops and output stream decode
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    size_d      = size_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    pkt_done_d  = 1'b0;
    fifo_pop    = 1'b0;
    out_valid   = 1'b0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    // A flit offered without credit is lost; remember it until reset
    ovf_d       = ovf_q | (link.rx & fifo_full);

    case (state_q)
      S_HDR: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hdr_d    = fifo_head;
          state_d  = S_SIZE;
        end
      end
      S_SIZE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          size_d      = fifo_head;
          remaining_d = fifo_head;
          if (fifo_head == '0) begin
            // Empty packet completes without ever touching the stream
            pkt_done_d = 1'b1;
            state_d    = S_HDR;
          end else begin
            first_d = 1'b1;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        out_valid = !fifo_empty;
        out_sop   = out_valid && first_q;
        out_eop   = out_valid && (remaining_q == FLIT_WIDTH'(1));
        if (out_valid && link.out_ready) begin
          fifo_pop = 1'b1;
          first_d  = 1'b0;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - FLIT_WIDTH'(1);
          end
          if (remaining_q == FLIT_WIDTH'(1)) begin
            pkt_done_d = 1'b1;
            state_d    = S_HDR;
          end
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // Parser state and packet-level registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HDR;
      hdr_q       <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      pkt_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      size_q      <= size_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      pkt_done_q  <= pkt_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign link.credit_o  = credit;
  assign link.out_valid = out_valid;
  assign link.out_data  = fifo_head;
  assign link.out_sop   = out_sop;
  assign link.out_eop   = out_eop;
  assign hdr_o          = hdr_q;
  assign size_o         = size_q;
  assign pkt_done_o     = pkt_done_q;
  assign ovf_o          = ovf_q;

`ifdef ROUTER_RX_PORT_STATS_EN
  logic [RX_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [RX_CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
  logic [RX_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Free-running event counters, wrapping modulo 2^32
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    flit_cnt_d  = flit_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pkt_done_d) pkt_cnt_d = pkt_cnt_q + RX_CNT_WIDTH'(1);
    if (fifo_push) flit_cnt_d = flit_cnt_q + RX_CNT_WIDTH'(1);
    if (out_valid && !link.out_ready) stall_cnt_d = stall_cnt_q + RX_CNT_WIDTH'(1);
  end

  // Statistics counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_rx_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_rx_port
//  Description : Directed self-checking bench for router_rx_port. Payload
//                flits are pushed to an expectation queue as they are sent
//                and compared when the DUT hands them over downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_rx_port;

  localparam int FW = 16;

  typedef struct packed {
    logic [FW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [FW-1:0] hdr_o;
  logic [FW-1:0] size_o;
  logic          pkt_done_o;
  logic          ovf_o;
`ifdef ROUTER_RX_PORT_STATS_EN
  logic [31:0]   pkt_cnt_o;
  logic [31:0]   flit_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  router_rx_port_if #(.FLIT_WIDTH(FW)) link ();

  router_rx_port #(
    .FLIT_WIDTH (FW),
    .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .link        (link),
    .hdr_o       (hdr_o),
    .size_o      (size_o),
    .pkt_done_o  (pkt_done_o),
    .ovf_o       (ovf_o)
`ifdef ROUTER_RX_PORT_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o),
    .flit_cnt_o  (flit_cnt_o),
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  int   checks     = 0;
  int   failures   = 0;
  int   done_cnt   = 0;
  int   stall_cnt  = 0;
  int   flit_acc   = 0;
  int   cyc        = 0;
  bit   credit_low = 1'b0;
  int   hs_cyc[$];
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observe away from the rising edge; a handshake seen here completes at the next edge
  always @(negedge clock) begin
    cyc++;
    if (pkt_done_o === 1'b1) done_cnt++;
    if (link.credit_o === 1'b0) credit_low = 1'b1;
    if (link.out_valid === 1'b1 && link.out_ready === 1'b0) stall_cnt++;
    if (link.out_valid === 1'b1 && link.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=0x%0h expected=no_flit", link.out_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(link.out_data), 32'(mon_e.data));
        chk("out_sop", 32'(link.out_sop), 32'(mon_e.sop));
        chk("out_eop", 32'(link.out_eop), 32'(mon_e.eop));
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one flit, waiting (with rx low) until credit is available
  task automatic send(input logic [FW-1:0] d);
    int n = 0;
    while (link.credit_o !== 1'b1 && n < 100) begin
      link.rx = 1'b0;
      step();
      n++;
    end
    if (n >= 100) chk("credit_timeout", 32'(n), 32'd0);
    link.rx     = 1'b1;
    link.data_i = d;
    step();
    flit_acc++;
  endtask

  task automatic send_pay(input logic [FW-1:0] d, input logic sop, input logic eop);
    sb.push_back(exp_t'{data: d, sop: sop, eop: eop});
    send(d);
  endtask

  task automatic idle(input int n);
    link.rx = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    link.rx = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            d0;
    int            span;
    logic [FW-1:0] pay [8];

    // ---------------- reset (rx held high must be ignored) ----------------
    reset          = 1'b1;
    link.rx        = 1'b1;
    link.data_i    = 16'hDEAD;
    link.out_ready = 1'b0;
    step();
    step();
    reset   = 1'b0;
    link.rx = 1'b0;
    chk("rst_credit", 32'(link.credit_o), 32'd1);
    chk("rst_out_valid", 32'(link.out_valid), 32'd0);
    chk("rst_sop", 32'(link.out_sop), 32'd0);
    chk("rst_eop", 32'(link.out_eop), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_hdr", 32'(hdr_o), 32'd0);
    chk("rst_size", 32'(size_o), 32'd0);
    idle(3);
    chk("rst_rx_ignored_hdr", 32'(hdr_o), 32'd0);
    chk("rst_rx_ignored_valid", 32'(link.out_valid), 32'd0);

    // ---------------- free flow ----------------
    link.out_ready = 1'b1;
    credit_low     = 1'b0;
    hs_cyc.delete();
    d0 = done_cnt;
    send(16'h0005);
    send(16'h0003);
    send_pay(16'hA1A1, 1'b1, 1'b0);
    chk("ff_latency_valid", 32'(link.out_valid), 32'd1);
    chk("ff_latency_sop", 32'(link.out_sop), 32'd1);
    chk("ff_latency_data", 32'(link.out_data), 32'hA1A1);
    send_pay(16'hB2B2, 1'b0, 1'b0);
    send_pay(16'hC3C3, 1'b0, 1'b1);
    drain("ff");
    chk("ff_hdr", 32'(hdr_o), 32'h5);
    chk("ff_size", 32'(size_o), 32'h3);
    chk("ff_pkt_done", 32'(done_cnt - d0), 32'd1);
    chk("ff_credit_never_low", 32'(credit_low), 32'd0);
    chk("ff_handshakes", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      span = hs_cyc[2] - hs_cyc[0];
      chk("ff_consecutive", 32'(span), 32'd2);
    end

    // ---------------- back-pressure ----------------
    for (int i = 0; i < 8; i++) pay[i] = 16'h5000 + 16'(i);
    link.out_ready = 1'b0;
    d0 = done_cnt;
    send(16'h0002);
    send(16'h0008);
    for (int i = 0; i < 4; i++) send_pay(pay[i], i == 0, 1'b0);
    chk("bp_credit_low", 32'(link.credit_o), 32'd0);
    chk("bp_valid", 32'(link.out_valid), 32'd1);
    chk("bp_head", 32'(link.out_data), 32'h5000);
    link.rx     = 1'b1;
    link.data_i = 16'h0BAD;
    step();
    step();
    link.rx = 1'b0;
    chk("bp_ovf_set", 32'(ovf_o), 32'd1);
    chk("bp_head_stable", 32'(link.out_data), 32'h5000);
    link.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_pay(pay[i], 1'b0, i == 7);
    drain("bp");
    chk("bp_pkt_done", 32'(done_cnt - d0), 32'd1);
    chk("bp_ovf_sticky", 32'(ovf_o), 32'd1);
    chk("bp_size", 32'(size_o), 32'h8);
`ifdef ROUTER_RX_PORT_STATS_EN
    chk("stats_pkt_cnt", pkt_cnt_o, 32'd2);
    chk("stats_flit_cnt", flit_cnt_o, 32'(flit_acc));
    chk("stats_stall_cnt", stall_cnt_o, 32'(stall_cnt));
`endif

    // ---------------- sender contention ----------------
    d0 = done_cnt;
    send(16'h0003);
    send(16'h0004);
    send_pay(16'h0002, 1'b1, 1'b0);
    send_pay(16'h0003, 1'b0, 1'b0);
    link.rx = 1'b0;
    step();
    chk("gap_valid_0", 32'(link.out_valid), 32'd0);
    step();
    chk("gap_valid_1", 32'(link.out_valid), 32'd0);
    send_pay(16'h0004, 1'b0, 1'b0);
    send_pay(16'h0005, 1'b0, 1'b1);
    drain("gap");
    chk("gap_pkt_done", 32'(done_cnt - d0), 32'd1);

    // ---------------- zero-size packet then one-flit packet ----------------
    d0 = done_cnt;
    send(16'h0009);
    send(16'h0000);
    send(16'h0001);
    send(16'h0001);
    send_pay(16'h0007, 1'b1, 1'b1);
    drain("zero");
    chk("zero_pkt_done", 32'(done_cnt - d0), 32'd2);
    chk("zero_hdr", 32'(hdr_o), 32'h1);
    chk("zero_size", 32'(size_o), 32'h1);

    // ---------------- reset mid-packet ----------------
    link.out_ready = 1'b0;
    send(16'h0003);
    send(16'h000A);
    for (int i = 0; i < 4; i++) send(16'h6000 + 16'(i));
    d0          = done_cnt;
    reset       = 1'b1;
    link.rx     = 1'b1;
    link.data_i = 16'h7777;
    step();
    reset   = 1'b0;
    link.rx = 1'b0;
    chk("mid_rst_credit", 32'(link.credit_o), 32'd1);
    chk("mid_rst_valid", 32'(link.out_valid), 32'd0);
    chk("mid_rst_sop", 32'(link.out_sop), 32'd0);
    chk("mid_rst_eop", 32'(link.out_eop), 32'd0);
    chk("mid_rst_hdr", 32'(hdr_o), 32'd0);
    chk("mid_rst_size", 32'(size_o), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_o), 32'd0);
`ifdef ROUTER_RX_PORT_STATS_EN
    chk("mid_rst_pkt_cnt", pkt_cnt_o, 32'd0);
    chk("mid_rst_flit_cnt", flit_cnt_o, 32'd0);
`endif
    idle(3);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_idle_valid", 32'(link.out_valid), 32'd0);
    link.out_ready = 1'b1;
    send(16'h0004);
    send(16'h0002);
    send_pay(16'h0011, 1'b1, 1'b0);
    send_pay(16'h0022, 1'b0, 1'b1);
    drain("post_rst");
    chk("post_rst_hdr", 32'(hdr_o), 32'h4);
    chk("post_rst_size", 32'(size_o), 32'h2);
    chk("post_rst_pkt_done", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
